result_stream_packer: RTL and testbench

Output-side stage that consumes the processor's 64-bit `data` word and its `enable` strobe, buffers words in a small FIFO and emits them as a byte stream, most significant byte first, over a valid/ready handshake. It sits directly downstream of `processor` and upstream of the byte sink (UART TX or capture logic). It decouples the processor's bursty result production from a slower sink. Lost words are reported, never silently hidden.

---
 rtl/asip_io_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/result_stream_packer.sv | 117 +++++++++++
 tb/tb_result_stream_packer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asip_io_pkg.sv
// Shared types and default sizing for the result output path.
// Modules take DATA_W/DEPTH as parameters; the DEF_* values here are the
// defaults, and BYTES_PER_WORD/PTR_W are derived from those defaults.
package asip_io_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  localparam int unsigned DEF_DATA_W     = 64;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned BYTES_PER_WORD = DEF_DATA_W / 8;
  localparam int unsigned PTR_W          = $clog2(DEF_DEPTH);

  // Width of a counter indexing n items; never less than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO.
//   clk, rst     : clock, asynchronous active-low reset
//   push/wr_data : write request; ignored when full
//   pop/rd_data  : read request; rd_data shows the head word combinationally
//   count        : words stored (0..DEPTH)
//   full, empty  : status flags derived from count
module sync_fifo
  import asip_io_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_stream_packer.sv
// Buffers processor result words and serialises them MSB-first as bytes
// over a valid/ready handshake.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid, in_data   : result word strobe and data from the processor
//   out_valid/out_ready : byte handshake toward the sink
//   out_byte, out_last  : current byte; out_last marks a word's LSB byte
//   fifo_count          : words queued, excluding the one being serialised
//   overflow, clr_ovf   : sticky dropped-word flag and its synchronous clear
module result_stream_packer
  import asip_io_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int unsigned BPW   = DATA_W / 8;
  localparam int unsigned IDX_W = idx_width(BPW);

  ser_state_t        state, state_d;
  logic [DATA_W-1:0] shift_reg, shift_d;
  logic [IDX_W-1:0]  byte_idx, idx_d;
  logic              pop;
  logic              is_last;
  logic              drop;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Fullness is judged before any same-cycle pop, so a word arriving at a
  // full FIFO is dropped even if a slot frees up on that edge.
  assign drop = in_valid && fifo_full;

  assign is_last   = (byte_idx == IDX_W'(BPW - 1));
  assign out_valid = (state == SEND);
  assign out_byte  = shift_reg[DATA_W-1 -: 8];
  assign out_last  = (state == SEND) && is_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      byte_idx  <= '0;
    end else begin
      state     <= state_d;
      shift_reg <= shift_d;
      byte_idx  <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    shift_d = shift_reg;
    idx_d   = byte_idx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!is_last) begin
            shift_d = shift_reg << 8;
            idx_d   = byte_idx + IDX_W'(1);
          end else if (!fifo_empty) begin
            // Reload directly from the FIFO head: no idle cycle between words.
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            idx_d   = '0;
          end else begin
            shift_d = shift_reg << 8;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_result_stream_packer.sv
module tb_result_stream_packer;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int BPW   = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_byte;
  logic          out_last;
  logic [4:0]    fifo_count;
  logic          overflow;
  logic          clr_ovf;

  result_stream_packer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus the bytes still to be
  // sent from the word currently being emitted.
  logic [DW-1:0] m_words[$];
  logic [7:0]    m_cur[$];
  bit            m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_words.delete();
      m_cur.delete();
      m_ovf = 1'b0;
    end else begin
      int     pre_n;
      bit     was_full;
      bit     acc;
      bit     want;
      logic [DW-1:0] w;
      logic [7:0]    tmp;
      pre_n    = m_words.size();
      was_full = (pre_n == DEPTH);
      acc      = (m_cur.size() != 0) && out_ready;
      want     = (m_cur.size() == 0) || (acc && m_cur.size() == 1);
      if (acc) tmp = m_cur.pop_front();
      if (want && pre_n > 0) begin
        w = m_words.pop_front();
        for (int b = 0; b < BPW; b++) m_cur.push_back(w[DW-1-8*b -: 8]);
      end
      if (in_valid && !was_full) m_words.push_back(in_data);
      if (in_valid && was_full) m_ovf = 1'b1;
      else if (clr_ovf)         m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, m_cur.size() != 0);
      chk("fifo_count", fifo_count, m_words.size());
      chk("overflow", overflow, m_ovf);
      if (m_cur.size() != 0) begin
        chk("out_byte", out_byte, m_cur[0]);
        chk("out_last", out_last, m_cur.size() == 1);
      end
    end
  end

  // Accepted-byte monitor for the literal checks.
  logic [7:0] got[$];
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_byte);
  end

  task automatic wait_bytes(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(name, got.size(), n);
  endtask

  logic [7:0]    l1[8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [DW-1:0] sent[$];
  logic [DW-1:0] wv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_last", out_last, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    // Single word, sink always ready.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_latency_k", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_byte", out_byte, l1[i]);
      chk("t1_last", out_last, i == 7);
    end
    @(negedge clk);
    chk("t1_drop_valid", out_valid, 0);

    // Backpressure with out_ready pattern 1,0,0,1,0,0,...
    got.delete();
    in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 80 && got.size() < 8; c++) begin
      out_ready = (c % 3 == 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("t2_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("t2_byte", got[i], l1[i]);
    repeat (2) @(negedge clk);

    // Back-to-back words.
    in_valid = 1'b1; in_data = {8{8'h11}};
    @(negedge clk);
    in_data = {8{8'h22}};
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_valid", out_valid, 1);
      chk("t3_byte", out_byte, (i < 8) ? 8'h11 : 8'h22);
      chk("t3_last", out_last, (i == 7) || (i == 15));
    end
    @(negedge clk);
    chk("t3_idle", out_valid, 0);

    // Overflow: 18 words into a stalled sink.
    out_ready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4_full_count", fifo_count, 16);
    chk("t4_ovf_set", overflow, 1);
    got.delete();
    out_ready = 1'b1;
    wait_bytes(17 * 8, 400, "t4_drained");
    @(negedge clk);
    for (int i = 0; i < 17 && (i * 8 + 7) < got.size(); i++) begin
      wv = '0;
      for (int b = 0; b < 8; b++) wv = (wv << 8) | DW'(got[i*8+b]);
      chk("t4_word", wv, i + 1);
    end
    chk("t4_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", overflow, 0);

    // Wrap-around: 40 random words, random sink readiness (75%).
    got.delete();
    sent.delete();
    for (int n = 0; n < 40; n++) begin
      int gap;
      wv = {$urandom, $urandom};
      sent.push_back(wv);
      in_valid = 1'b1; in_data = wv;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      in_valid = 1'b0;
      gap = $urandom_range(8, 24);
      for (int g = 0; g < gap; g++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    wait_bytes(320, 600, "t5_bytes");
    @(negedge clk);
    for (int i = 0; i < 320 && i < got.size(); i++) begin
      wv = sent[i / 8];
      chk("t5_byte", got[i], wv[DW-1-8*(i%8) -: 8]);
    end
    chk("t5_ovf", overflow, 0);
    chk("t5_count", fifo_count, 0);

    // Reset asserted during the third byte of a word, with another queued.
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    in_data = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_byte0", out_byte, 8'hDE);
    repeat (2) @(negedge clk);
    chk("t6_byte2", out_byte, 8'hBE);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_byte", out_byte, 0);
    chk("t6_rst_last", out_last, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got.delete();
    in_valid = 1'b1; in_data = {8{8'hA5}};
    @(negedge clk);
    in_valid = 1'b0;
    wait_bytes(8, 40, "t6_bytes");
    repeat (2) @(negedge clk);
    chk("t6_no_extra", got.size(), 8);
    for (int i = 0; i < got.size(); i++) chk("t6_a5", got[i], 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
